// File: rtl/matrix_load_sequencer_pkg.sv
// Shared types and header layout for the serial matrix loader.
// Also holds the helper that derives the header field width.
package matrix_load_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_LOAD_B = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } load_state_e;

    // Header fields arrive M, K, N, each MSB-first.
    localparam int HDR_FIELDS = 3;
    localparam int HDR_M_IDX  = 0;
    localparam int HDR_K_IDX  = 1;
    localparam int HDR_N_IDX  = 2;

    function automatic int calc_dim_w(input int max_m, input int max_k, input int max_n);
        int mx;
        mx = (max_m > max_k) ? ((max_m > max_n) ? max_m : max_n)
                             : ((max_k > max_n) ? max_k : max_n);
        return $clog2(mx) + 1;
    endfunction

endpackage

// File: rtl/matrix_load_sequencer_serial_elem_packer.sv
// Bit-serial element deserializer and vector packer, shared by the A-row and
// B-column phases; sel_b picks which vector count terminates the phase.
module serial_elem_packer #(
    parameter int ELEM_W = 8,
    parameter int MAX_K  = 32,
    parameter int DIM_W  = 6,
    parameter int IDX_W  = 5
) (
    input  logic                      eth_refclk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      shift_en,
    input  logic                      bit_in,
    input  logic                      sel_b,
    input  logic [DIM_W-1:0]          k_len,
    input  logic [DIM_W-1:0]          m_len,
    input  logic [DIM_W-1:0]          n_len,
    output logic [MAX_K*ELEM_W-1:0]   vec_word,
    output logic                      vec_done,
    output logic                      vec_last,
    output logic [IDX_W-1:0]          vec_idx
);

    localparam int VEC_W  = MAX_K * ELEM_W;
    localparam int BIT_CW = $clog2(ELEM_W);
    localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(ELEM_W - 1);

    logic [ELEM_W-2:0]  elem_shift_r;
    logic [BIT_CW-1:0]  bit_cnt_r;
    logic [DIM_W-1:0]   elem_cnt_r;
    logic [IDX_W-1:0]   vec_idx_r;
    logic [VEC_W-1:0]   row_r;

    logic [ELEM_W-1:0]  elem_next_s;
    logic [VEC_W-1:0]   row_next_s;
    logic [DIM_W-1:0]   vec_len_s;
    logic               elem_full_s;
    logic               row_full_s;
    logic               vec_last_s;

    // Merge the incoming bit so a full vector is visible on the sampling cycle.
    always_comb begin
        elem_next_s = {elem_shift_r, bit_in};
        elem_full_s = shift_en && (bit_cnt_r == LAST_BIT);
        row_full_s  = elem_full_s && (elem_cnt_r == (k_len - DIM_W'(1)));
        if (sel_b) begin
            vec_len_s = n_len;
        end else begin
            vec_len_s = m_len;
        end
        vec_last_s  = row_full_s && (vec_idx_r == IDX_W'(vec_len_s - DIM_W'(1)));
        row_next_s  = row_r;
        row_next_s[elem_cnt_r * ELEM_W +: ELEM_W] = elem_next_s;
    end

    assign vec_word = row_next_s;
    assign vec_done = row_full_s;
    assign vec_last = vec_last_s;
    assign vec_idx  = vec_idx_r;

    // Bit, element and vector counters; the row register clears as it is handed off.
    always_ff @(posedge eth_refclk) begin
        if (rst || clear) begin
            elem_shift_r <= '0;
            bit_cnt_r    <= '0;
            elem_cnt_r   <= '0;
            vec_idx_r    <= '0;
            row_r        <= '0;
        end else if (shift_en) begin
            if (elem_full_s) begin
                elem_shift_r <= '0;
                bit_cnt_r    <= '0;
                if (row_full_s) begin
                    row_r      <= '0;
                    elem_cnt_r <= '0;
                    vec_idx_r  <= vec_last_s ? '0 : vec_idx_r + IDX_W'(1);
                end else begin
                    row_r      <= row_next_s;
                    elem_cnt_r <= elem_cnt_r + DIM_W'(1);
                end
            end else begin
                elem_shift_r <= elem_next_s[ELEM_W-2:0];
                bit_cnt_r    <= bit_cnt_r + BIT_CW'(1);
            end
        end
    end

endmodule

// File: rtl/matrix_load_sequencer.sv
// Parses a bit-serial matrix frame and writes A rows / B columns into the
// dual-clock BRAM write ports, flagging completion and malformed frames.
module matrix_load_sequencer
    import matrix_load_pkg::*;
#(
    parameter int ELEM_W = 8,
    parameter int MAX_M  = 32,
    parameter int MAX_K  = 32,
    parameter int MAX_N  = 32,
    localparam int DIM_W = calc_dim_w(MAX_M, MAX_K, MAX_N)
) (
    input  logic                      eth_refclk,
    input  logic                      rst,
    input  logic                      axiiv,
    input  logic                      axiid,
    output logic                      a_we,
    output logic [$clog2(MAX_M)-1:0]  a_addr,
    output logic [MAX_K*ELEM_W-1:0]   a_din,
    output logic                      b_we,
    output logic [$clog2(MAX_N)-1:0]  b_addr,
    output logic [MAX_K*ELEM_W-1:0]   b_din,
    output logic [DIM_W-1:0]          m_out,
    output logic [DIM_W-1:0]          k_out,
    output logic [DIM_W-1:0]          n_out,
    output logic                      busy,
    output logic                      complete,
    output logic                      err
);

    localparam int A_AW     = $clog2(MAX_M);
    localparam int B_AW     = $clog2(MAX_N);
    localparam int IDX_W    = (A_AW > B_AW) ? A_AW : B_AW;
    localparam int VEC_W    = MAX_K * ELEM_W;
    localparam int HDR_BITS = HDR_FIELDS * DIM_W;
    localparam int HDR_CW   = $clog2(HDR_BITS + 1);
    localparam logic [HDR_CW-1:0] HDR_LAST = HDR_CW'(HDR_BITS - 1);
    localparam logic [DIM_W-1:0]  MAX_M_D  = DIM_W'(MAX_M);
    localparam logic [DIM_W-1:0]  MAX_K_D  = DIM_W'(MAX_K);
    localparam logic [DIM_W-1:0]  MAX_N_D  = DIM_W'(MAX_N);

    function automatic logic [DIM_W-1:0] hdr_field(input logic [HDR_BITS-1:0] hdr, input int idx);
        return hdr[(HDR_FIELDS - 1 - idx) * DIM_W +: DIM_W];
    endfunction

    load_state_e          state_r, state_next_s;
    logic [HDR_BITS-2:0]  hdr_shift_r;
    logic [HDR_CW-1:0]    hdr_cnt_r;
    logic [HDR_BITS-1:0]  hdr_next_s;
    logic [DIM_W-1:0]     hdr_m_s, hdr_k_s, hdr_n_s;
    logic                 hdr_ok_s, hdr_last_s, in_load_s, live_s;

    logic                 a_we_r, b_we_r, busy_r, complete_r, err_r;
    logic [A_AW-1:0]      a_addr_r;
    logic [B_AW-1:0]      b_addr_r;
    logic [VEC_W-1:0]     a_din_r, b_din_r;
    logic [DIM_W-1:0]     m_r, k_r, n_r;

    logic [VEC_W-1:0]     pk_word_s;
    logic                 pk_done_s, pk_last_s;
    logic [IDX_W-1:0]     pk_idx_s;

    serial_elem_packer #(
        .ELEM_W (ELEM_W),
        .MAX_K  (MAX_K),
        .DIM_W  (DIM_W),
        .IDX_W  (IDX_W)
    ) u_packer (
        .eth_refclk (eth_refclk),
        .rst        (rst),
        .clear      (!in_load_s),
        .shift_en   (axiiv && in_load_s),
        .bit_in     (axiid),
        .sel_b      (state_r == ST_LOAD_B),
        .k_len      (k_r),
        .m_len      (m_r),
        .n_len      (n_r),
        .vec_word   (pk_word_s),
        .vec_done   (pk_done_s),
        .vec_last   (pk_last_s),
        .vec_idx    (pk_idx_s)
    );

    // Header decode uses the bit being sampled so the check lands on the last header bit.
    always_comb begin
        hdr_next_s = {hdr_shift_r, axiid};
        hdr_m_s    = hdr_field(hdr_next_s, HDR_M_IDX);
        hdr_k_s    = hdr_field(hdr_next_s, HDR_K_IDX);
        hdr_n_s    = hdr_field(hdr_next_s, HDR_N_IDX);
        hdr_ok_s   = (hdr_m_s != '0) && (hdr_m_s <= MAX_M_D) &&
                     (hdr_k_s != '0) && (hdr_k_s <= MAX_K_D) &&
                     (hdr_n_s != '0) && (hdr_n_s <= MAX_N_D);
        hdr_last_s = (state_r == ST_HEADER) && axiiv && (hdr_cnt_r == HDR_LAST);
        in_load_s  = (state_r == ST_LOAD_A) || (state_r == ST_LOAD_B);
        live_s     = in_load_s || (state_r == ST_HEADER);
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (axiiv) state_next_s = ST_HEADER;
                else       state_next_s = ST_IDLE;
            end
            ST_HEADER: begin
                if (!axiiv)          state_next_s = ST_IDLE;
                else if (hdr_last_s) state_next_s = hdr_ok_s ? ST_LOAD_A : ST_ERROR;
                else                 state_next_s = ST_HEADER;
            end
            ST_LOAD_A: begin
                if (!axiiv)         state_next_s = ST_IDLE;
                else if (pk_last_s) state_next_s = ST_LOAD_B;
                else                state_next_s = ST_LOAD_A;
            end
            ST_LOAD_B: begin
                if (!axiiv)         state_next_s = ST_IDLE;
                else if (pk_last_s) state_next_s = ST_DONE;
                else                state_next_s = ST_LOAD_B;
            end
            ST_DONE, ST_ERROR: begin
                if (!axiiv) state_next_s = ST_IDLE;
                else        state_next_s = state_r;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge eth_refclk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_next_s;
    end

    // Header shifter and registered outputs.
    always_ff @(posedge eth_refclk) begin
        if (rst) begin
            hdr_shift_r <= '0;
            hdr_cnt_r   <= '0;
            a_we_r      <= 1'b0;
            a_addr_r    <= '0;
            a_din_r     <= '0;
            b_we_r      <= 1'b0;
            b_addr_r    <= '0;
            b_din_r     <= '0;
            m_r         <= '0;
            k_r         <= '0;
            n_r         <= '0;
            busy_r      <= 1'b0;
            complete_r  <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            a_we_r <= 1'b0;
            b_we_r <= 1'b0;
            busy_r <= (state_next_s == ST_HEADER) || (state_next_s == ST_LOAD_A) ||
                      (state_next_s == ST_LOAD_B);
            err_r  <= ((state_next_s == ST_ERROR) && (state_r != ST_ERROR)) ||
                      (live_s && !axiiv);
            if ((state_r == ST_IDLE) && axiiv) begin
                hdr_shift_r <= {{(HDR_BITS-2){1'b0}}, axiid};
                hdr_cnt_r   <= HDR_CW'(1);
                complete_r  <= 1'b0;
            end else if ((state_r == ST_HEADER) && axiiv) begin
                hdr_shift_r <= hdr_next_s[HDR_BITS-2:0];
                hdr_cnt_r   <= hdr_cnt_r + HDR_CW'(1);
            end
            if (hdr_last_s && hdr_ok_s) begin
                m_r <= hdr_m_s;
                k_r <= hdr_k_s;
                n_r <= hdr_n_s;
            end
            if (pk_done_s && (state_r == ST_LOAD_A)) begin
                a_we_r   <= 1'b1;
                a_addr_r <= A_AW'(pk_idx_s);
                a_din_r  <= pk_word_s;
            end
            if (pk_done_s && (state_r == ST_LOAD_B)) begin
                b_we_r   <= 1'b1;
                b_addr_r <= B_AW'(pk_idx_s);
                b_din_r  <= pk_word_s;
                if (pk_last_s) complete_r <= 1'b1;
            end
        end
    end

    assign a_we     = a_we_r;
    assign a_addr   = a_addr_r;
    assign a_din    = a_din_r;
    assign b_we     = b_we_r;
    assign b_addr   = b_addr_r;
    assign b_din    = b_din_r;
    assign m_out    = m_r;
    assign k_out    = k_r;
    assign n_out    = n_r;
    assign busy     = busy_r;
    assign complete = complete_r;
    assign err      = err_r;

endmodule

// File: tb/tb_matrix_load_sequencer.sv
// Frame-level bench: a table of frames is serialized, and each cycle's outputs
// are compared with write positions derived from frame arithmetic.
module tb_matrix_load_sequencer;

    localparam int EW = 8;
    localparam int DW = 6;
    localparam int H  = 3 * DW;
    localparam int VW = 32 * EW;

    logic          eth_refclk = 1'b0;
    logic          rst, axiiv, axiid;
    logic          a_we, b_we, busy, complete, err;
    logic [4:0]    a_addr, b_addr;
    logic [VW-1:0] a_din, b_din;
    logic [DW-1:0] m_out, k_out, n_out;

    int total_cnt = 0;
    int bad_cnt   = 0;

    typedef struct {
        int m, k, n;
        int send;      // bits sent; -1 = full frame plus extra
        int extra;
        int rst_at;    // bit index at which rst is raised; -1 = never
        bit fixed;
        int exp_a, exp_b;
        bit exp_c;
        int exp_err;
    } vec_t;

    vec_t          tbl [0:14];
    logic [7:0]    ma [0:33][0:33];
    logic [7:0]    mb [0:33][0:33];
    bit            bq [$];
    logic [VW-1:0] cap_a [$];
    logic [VW-1:0] cap_b [$];
    logic [DW-1:0] pm = '0, pk = '0, pn = '0;

    matrix_load_sequencer dut (
        .eth_refclk (eth_refclk), .rst (rst), .axiiv (axiiv), .axiid (axiid),
        .a_we (a_we), .a_addr (a_addr), .a_din (a_din),
        .b_we (b_we), .b_addr (b_addr), .b_din (b_din),
        .m_out (m_out), .k_out (k_out), .n_out (n_out),
        .busy (busy), .complete (complete), .err (err)
    );

    always #5 eth_refclk = ~eth_refclk;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int m, input int k, input int n, input int send,
                                input int extra, input int rst_at, input bit fixed,
                                input int ea, input int eb, input bit ec, input int ee);
        vec_t v;
        v.m = m; v.k = k; v.n = n; v.send = send; v.extra = extra; v.rst_at = rst_at;
        v.fixed = fixed; v.exp_a = ea; v.exp_b = eb; v.exp_c = ec; v.exp_err = ee;
        return v;
    endfunction

    task automatic cycle();
        @(posedge eth_refclk);
        @(negedge eth_refclk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a_we"}, a_we, '0);     chk({tag, "_b_we"}, b_we, '0);
        chk({tag, "_a_addr"}, a_addr, '0); chk({tag, "_b_addr"}, b_addr, '0);
        chk({tag, "_a_din"}, a_din, '0);   chk({tag, "_b_din"}, b_din, '0);
        chk({tag, "_m"}, m_out, '0);       chk({tag, "_k"}, k_out, '0);
        chk({tag, "_n"}, n_out, '0);       chk({tag, "_busy"}, busy, '0);
        chk({tag, "_complete"}, complete, '0);
        chk({tag, "_err"}, err, '0);
    endtask

    task automatic run_case(input vec_t v);
        int tot, la, lb, rl, nsend, na, nb, nerr, row;
        bit hv, e_a, e_b, aborted, e_derr;
        logic [VW-1:0] w;
        hv = (v.m > 0) && (v.m <= 32) && (v.k > 0) && (v.k <= 32) && (v.n > 0) && (v.n <= 32);
        la = v.m * v.k * EW;
        lb = v.k * v.n * EW;
        rl = v.k * EW;
        tot = H + la + lb;
        for (int r = 0; r < v.m; r++)
            for (int c = 0; c < v.k; c++)
                ma[r][c] = v.fixed ? 8'(r * v.k + c + 1) : 8'($urandom_range(0, 255));
        for (int c = 0; c < v.n; c++)
            for (int j = 0; j < v.k; j++)
                mb[j][c] = v.fixed ? 8'(v.m * v.k + c * v.k + j + 1) : 8'($urandom_range(0, 255));
        bq.delete();
        for (int b = DW - 1; b >= 0; b--) bq.push_back(bit'((v.m >> b) & 1));
        for (int b = DW - 1; b >= 0; b--) bq.push_back(bit'((v.k >> b) & 1));
        for (int b = DW - 1; b >= 0; b--) bq.push_back(bit'((v.n >> b) & 1));
        for (int r = 0; r < v.m; r++)
            for (int c = 0; c < v.k; c++)
                for (int b = EW - 1; b >= 0; b--) bq.push_back(ma[r][c][b]);
        for (int c = 0; c < v.n; c++)
            for (int j = 0; j < v.k; j++)
                for (int b = EW - 1; b >= 0; b--) bq.push_back(mb[j][c][b]);
        nsend = (v.send >= 0) ? v.send : tot + v.extra;
        for (int i = 0; i < v.extra; i++) bq.push_back(bit'($urandom_range(0, 1)));
        cap_a.delete();
        cap_b.delete();
        na = 0; nb = 0; nerr = 0; aborted = 1'b0;

        for (int t = 1; t <= nsend; t++) begin
            axiiv = 1'b1;
            axiid = bq[t-1];
            rst   = (t == v.rst_at);
            cycle();
            if (t == v.rst_at) begin
                check_all_zero("rst_mid");
                pm = '0; pk = '0; pn = '0;
                rst = 1'b0; axiiv = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    cycle();
                    chk("post_rst_a_we", a_we, '0);
                    chk("post_rst_b_we", b_we, '0);
                    chk("post_rst_err", err, '0);
                end
                aborted = 1'b1;
                break;
            end
            na += int'(a_we);
            nb += int'(b_we);
            nerr += int'(err);
            e_a = 1'b0; e_b = 1'b0;
            if (hv) begin
                e_a = (t > H) && (t <= H + la) && ((t - H) % rl == 0);
                e_b = (t > H + la) && (t <= tot) && ((t - H - la) % rl == 0);
            end
            chk("a_we", a_we, e_a);
            chk("b_we", b_we, e_b);
            chk("err", err, (!hv && t == H));
            chk("busy", busy, hv ? (t < tot) : (t < H));
            chk("complete", complete, (hv && t >= tot));
            if (e_a) begin
                row = (t - H) / rl - 1;
                w = '0;
                for (int j = 0; j < v.k; j++) w[j*EW +: EW] = ma[row][j];
                chk("a_addr", a_addr, row);
                chk("a_din", a_din, w);
                cap_a.push_back(a_din);
            end
            if (e_b) begin
                row = (t - H - la) / rl - 1;
                w = '0;
                for (int j = 0; j < v.k; j++) w[j*EW +: EW] = mb[j][row];
                chk("b_addr", b_addr, row);
                chk("b_din", b_din, w);
                cap_b.push_back(b_din);
            end
            if (hv && t == H) begin
                pm = DW'(v.m); pk = DW'(v.k); pn = DW'(v.n);
            end
        end

        if (!aborted) begin
            axiiv = 1'b0;
            axiid = 1'b0;
            cycle();
            e_derr = (nsend < H) || (hv && nsend < tot);
            nerr += int'(err);
            chk("drop_err", err, e_derr);
            chk("drop_busy", busy, '0);
            chk("drop_a_we", a_we, '0);
            chk("drop_b_we", b_we, '0);
            chk("drop_complete", complete, v.exp_c);
            cycle();
            chk("idle_complete", complete, v.exp_c);
            chk("idle_err", err, '0);
        end
        chk("n_a_writes", na, v.exp_a);
        chk("n_b_writes", nb, v.exp_b);
        chk("n_err", nerr, v.exp_err);
        chk("m_out", m_out, pm);
        chk("k_out", k_out, pk);
        chk("n_out", n_out, pn);
    endtask

    initial begin
        tbl[0]  = mk( 2,  3, 2, -1, 0, -1, 1,  2, 2, 1, 0);
        tbl[1]  = mk( 0,  3, 2, 30, 0, -1, 0,  0, 0, 0, 1);
        tbl[2]  = mk( 2,  3, 2, 28, 0, -1, 0,  0, 0, 0, 1);
        tbl[3]  = mk( 2,  3, 2, -1, 0, -1, 0,  2, 2, 1, 0);
        tbl[4]  = mk(32, 32, 1, -1, 0, -1, 0, 32, 1, 1, 0);
        tbl[5]  = mk( 3,  2, 4, -1, 5, -1, 0,  3, 4, 1, 0);
        tbl[6]  = mk( 4,  3, 5, -1, 0, -1, 0,  4, 5, 1, 0);
        tbl[7]  = mk(33,  1, 1, 25, 0, -1, 0,  0, 0, 0, 1);
        tbl[8]  = mk( 1, 33, 1, 20, 0, -1, 0,  0, 0, 0, 1);
        tbl[9]  = mk( 1,  1, 1, -1, 0, -1, 0,  1, 1, 1, 0);
        tbl[10] = mk( 2,  2, 3, -1, 0, 70, 0,  2, 1, 0, 0);
        tbl[11] = mk( 1,  4, 2, -1, 0, -1, 0,  1, 2, 1, 0);
        tbl[12] = mk( 2,  2, 2,  7, 0, -1, 0,  0, 0, 0, 1);
        tbl[13] = mk( 1,  1, 0, 20, 0, -1, 0,  0, 0, 0, 1);
        tbl[14] = mk( 2,  3, 1, -1, 3, -1, 0,  2, 1, 1, 0);

        rst = 1'b1; axiiv = 1'b0; axiid = 1'b0;
        repeat (2) @(posedge eth_refclk);
        @(negedge eth_refclk);
        check_all_zero("reset");
        rst = 1'b0;
        cycle();

        for (int i = 0; i < 15; i++) begin
            run_case(tbl[i]);
            if (i == 0) begin
                chk("fixed_a0", (cap_a.size() > 0) ? cap_a[0] : '1, {{(VW-24){1'b0}}, 24'h030201});
                chk("fixed_a1", (cap_a.size() > 1) ? cap_a[1] : '1, {{(VW-24){1'b0}}, 24'h060504});
                chk("fixed_b0", (cap_b.size() > 0) ? cap_b[0] : '1, {{(VW-24){1'b0}}, 24'h090807});
                chk("fixed_b1", (cap_b.size() > 1) ? cap_b[1] : '1, {{(VW-24){1'b0}}, 24'h0C0B0A});
            end
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/matrix_load_sequencer.md
Name: matrix_load_sequencer

Overview:
Receives a bit-serial matrix frame on eth_refclk (axiiv/axiid) and parses a header giving dimensions M, K and N. It then packs matrix A row-major into whole-row words and matrix B column-major into whole-column words. It drives the write ports of the A-row and B-column dual-clock BRAMs: one write per row or column, with the address equal to the row or column index. It reports completion and frame errors to the downstream multiply scheduler.

Parameters:
ELEM_W, 8, bits per matrix element
MAX_M, 32, max rows of A (A BRAM depth)
MAX_K, 32, max shared dimension (elements per BRAM word)
MAX_N, 32, max cols of B (B BRAM depth)
DIM_W, $clog2(MAX_M>MAX_K?(MAX_M>MAX_N?MAX_M:MAX_N):(MAX_K>MAX_N?MAX_K:MAX_N))+1, header field width (derived, localparam)

Ports:
eth_refclk  in  1  clock
rst  in  1  reset, synchronous, active-high
axiiv  in  1  frame valid; high for the whole frame
axiid  in  1  serial data bit, MSB-first
a_we  out  1  A BRAM write enable (1-cycle pulse)
a_addr  out  $clog2(MAX_M)  A row index
a_din  out  MAX_K*ELEM_W  packed A row
b_we  out  1  B BRAM write enable (1-cycle pulse)
b_addr  out  $clog2(MAX_N)  B column index
b_din  out  MAX_K*ELEM_W  packed B column
m_out, k_out, n_out  out  DIM_W each  latched dimensions of the last valid header
busy  out  1  frame in progress
complete  out  1  level; all M rows and N columns written
err  out  1  1-cycle pulse on frame error

Behaviour:
- Reset: all outputs 0; state IDLE; counters and shift registers cleared. Reset mid-frame aborts with no further writes and no err pulse.
- Frame format, one bit per cycle when axiiv=1, MSB-first:
  - M, then K, then N, DIM_W bits each.
  - Then M*K elements of A, row-major.
  - Then K*N elements of B, column-major.
- States and transitions:
  - IDLE: axiiv=1 → HEADER, and this first bit is consumed. complete clears in the same cycle.
  - HEADER: after 3*DIM_W bits, check each dimension.
    - Any dimension 0, or M>MAX_M, K>MAX_K, N>MAX_N → ERROR.
    - Otherwise latch m_out/k_out/n_out and go to LOAD_A.
  - LOAD_A: shift elements into the row register.
    - Element j of a row occupies a_din[j*ELEM_W +: ELEM_W]; bits at index K and above are 0.
    - After the last bit of element K-1, the next cycle has a_we=1 and a_addr=row.
    - After row M-1 is written → LOAD_B.
  - LOAD_B: same as LOAD_A, indexed by column; b_din[j*ELEM_W +: ELEM_W] = B[j][col].
    - After the final column write → DONE.
    - complete=1 in the same cycle as the final b_we.
  - DONE: remaining frame bits are ignored. axiiv=0 → IDLE; complete holds.
  - ERROR: err pulses on entry; no writes. Wait for axiiv=0, then → IDLE.
- axiiv=0 in HEADER, LOAD_A or LOAD_B (truncated frame) → err pulse, → IDLE.
  - A partially accumulated row or column is discarded and not written.
  - complete stays 0.
- Write latency: exactly 1 cycle from sampling the last bit of a row or column to the we pulse.
  - a_din/b_din and the address are stable during the we cycle.
  - The row register clears in the same cycle, so back-to-back rows need no idle gap.
- busy = 1 in HEADER, LOAD_A and LOAD_B.
- Row, column and element counters never wrap: they are compared against the latched M/K/N, not MAX.

Decomposition:
- Package matrix_load_pkg holds:
  - typedef enum of the states IDLE, HEADER, LOAD_A, LOAD_B, DONE, ERROR;
  - the DIM_W computation function;
  - the header field order constants.
- One sub-module: serial_elem_packer. It is a bit→element deserializer plus row packer with element and vector counters, instantiated once and reused for A and B via a select.

Test Plan:
- M=2, K=3, N=2. A = 1..6 row-major, B = 7..12 column-major, 114 bits total.
  - a_we at addr0 with a_din[23:0]=0x030201, then addr1 with 0x060504.
  - b_we at addr0 with b_din[23:0]=0x090807, then addr1 with 0x0C0B0A.
  - complete rises with the final b_we, one cycle after bit 114.
- Header M=0 → err pulse after bit 18; no a_we/b_we; IDLE once axiiv=0.
- axiiv drops after 10 A-payload bits → err pulse; no writes; complete=0. A following valid frame completes normally.
- M=MAX_M=32, K=32, N=1, random data → 32 A writes with addresses 0..31, full-width a_din, 1 B write, complete=1.
- rst asserted mid-LOAD_B → all outputs 0 next cycle; no further writes; a new frame is accepted afterwards.
- 5 extra bits after a complete frame → ignored; complete holds until the next frame's first bit.
